mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised memory arbiter and bus-width adapter between the pipeline's memory clients (instruction fetch, load/store stage, and any later masters) and a single external memory port. Each client issues a 32-bit word access with byte selects. The block grants one client at a time, by fixed priority or round-robin. It splits the access into narrow beats on the external bus and returns assembled read data with a one-cycle completion pulse. Clients stall on `stallreq` until served.

## Interface

- N_PORTS, 2, number of client ports (port 0 = instruction fetch by convention)
- ADDR_W, 32, address width
- BUS_BYTES, 1, external data bus width in bytes; legal values 1, 2, 4; any other value must fail elaboration
- PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  N_PORTS  client i requests; held until its req_done
- req_we  in  N_PORTS  1 = write, 0 = read
- req_addr  in  N_PORTS*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
- req_sel  in  N_PORTS*4  byte selects, port i at [i*4 +: 4]
- req_wdata  in  N_PORTS*32  write data, port i at [i*32 +: 32]
- req_done  out  N_PORTS  one-cycle completion pulse to the granted port
- rdata  out  32  assembled read word, valid while req_done is high
- stallreq  out  N_PORTS  combinational: req_valid[i] & ~req_done[i]
- ext_ce  out  1  external beat request
- ext_we  out  1  beat is a write
- ext_addr  out  ADDR_W  beat byte address
- ext_mask  out  BUS_BYTES  byte enables for the write beat
- ext_wdata  out  8*BUS_BYTES  write beat data
- ext_rdata  in  8*BUS_BYTES  read beat data
- ext_ready  in  1  memory completes the current beat at this rising edge

## Operation

- NBEATS = 4/BUS_BYTES. Word base = {addr[ADDR_W-1:2], 2'b00}. Beat k address = base + k*BUS_BYTES. Little-endian lanes: beat k carries word bytes [k*BUS_BYTES +: BUS_BYTES].
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any req_valid is high, select the winner, latch its we/addr/sel/wdata, set beat=0, and go to BUSY. Otherwise stay.
- Fixed priority: lowest requesting index wins. A continuously requesting low index starves higher indices; this is accepted behaviour.
- Round-robin: the winner is the first requesting index after last_grant, cyclically. last_grant resets to N_PORTS-1, so port 0 wins first.
- BUSY: ext_ce=1. ext_addr, ext_we, ext_mask (= sel bits of beat, forced 0 for reads) and ext_wdata are held stable until ext_ready. When ext_ready is high:
  - store ext_rdata into the beat's byte lanes of the read buffer;
  - if beat==NBEATS-1, go to DONE; otherwise increment beat.
- All beats are issued regardless of sel; a write beat with mask 0 is still issued.
- DONE: ext_ce=0, req_done[winner]=1, rdata = assembled word (reads). Next state is IDLE.
- rdata holds its value until the next read completes. It is undefined-but-stable after writes; in practice it is unchanged.
- If the winner drops req_valid mid-transaction, the transaction still completes and req_done still pulses.
- Requests arriving in BUSY or DONE wait; they are evaluated only in IDLE.

## Timing

- Reset (rst low, asynchronous): FSM=IDLE; req_done, ext_ce, ext_we, ext_addr, ext_mask, ext_wdata, rdata all 0; last_grant = N_PORTS-1. Effective immediately, even mid-beat.
- All outputs except stallreq are registered.
- Zero-wait memory (ext_ready constant 1): request sampled at edge E0. Beats occupy cycles 1..NBEATS. req_done is high in cycle NBEATS+1. A new grant can be sampled at the edge ending that cycle's following IDLE cycle.
- Throughput: one access per NBEATS+2 cycles.
- Each low cycle of ext_ready extends the current beat by one cycle.
- A beat with ext_ready high in its first cycle lasts exactly one cycle.

## Test plan

- Reset mid-transfer: assert rst low during beat 2 of a read -> ext_ce, req_done, and stallreq-related state clear in the same cycle. After release, the FSM is IDLE and the first request is served normally.
- Read, BUS_BYTES=1, ext_ready=1, addr 0x1003, memory bytes 0x11,0x22,0x33,0x44 at 0x1000..0x1003 -> ext_addr 0x1000,0x1001,0x1002,0x1003 in cycles 1-4; req_done[0] high in cycle 5 with rdata=0x44332211.
- Write with waits, BUS_BYTES=2, addr 0x2000, sel=4'b1100, wdata 0xAABBCCDD, ext_ready high every 3rd cycle:
  - beat 0: addr 0x2000, mask 2'b00, data 0xCCDD, held 3 cycles;
  - beat 1: addr 0x2002, mask 2'b11, data 0xAABB;
  - then a single req_done pulse.
- Fixed priority, N_PORTS=2, both ports request in the same cycle -> port 0 is served first while stallreq[1] stays high. Port 1 is served next only if port 0 has dropped its request.
- Round-robin, both ports hold req_valid continuously -> completions alternate 0,1,0,1 and neither port waits more than one transaction.
- BUS_BYTES=4, read at 0x40 -> a single beat with ext_addr 0x40 in cycle 1; req_done high in cycle 2 with rdata equal to ext_rdata.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - multi-client memory arbiter and word-to-beat bus width adapter
// Purpose: grants one 32-bit client access at a time (fixed priority or
//   round-robin), splits it into 4/BUS_BYTES little-endian beats on the
//   external port, and returns the assembled read word with a done pulse.
// Ports:
//   i_clk, i_rst               clock, asynchronous active-low reset
//   i_req_valid/we/addr/sel/   per-client request bundle, flattened by port
//   i_req_wdata
//   o_req_done, o_rdata        one-cycle completion pulse, assembled read word
//   o_stallreq                 combinational stall: valid and not done
//   o_ext_ce/we/addr/mask/     registered external beat request
//   o_ext_wdata
//   i_ext_rdata, i_ext_ready   read beat data, beat completion
module mem_arbiter #(
  parameter int N_PORTS   = 2,
  parameter int ADDR_W    = 32,
  parameter int BUS_BYTES = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_PORTS-1:0]        i_req_valid,
  input  logic [N_PORTS-1:0]        i_req_we,
  input  logic [N_PORTS*ADDR_W-1:0] i_req_addr,
  input  logic [N_PORTS*4-1:0]      i_req_sel,
  input  logic [N_PORTS*32-1:0]     i_req_wdata,
  output logic [N_PORTS-1:0]        o_req_done,
  output logic [31:0]               o_rdata,
  output logic [N_PORTS-1:0]        o_stallreq,
  output logic                      o_ext_ce,
  output logic                      o_ext_we,
  output logic [ADDR_W-1:0]         o_ext_addr,
  output logic [BUS_BYTES-1:0]      o_ext_mask,
  output logic [8*BUS_BYTES-1:0]    o_ext_wdata,
  input  logic [8*BUS_BYTES-1:0]    i_ext_rdata,
  input  logic                      i_ext_ready
);
  localparam int NBEATS = 4 / BUS_BYTES;
  localparam int LW     = 8 * BUS_BYTES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  generate
    if (BUS_BYTES != 1 && BUS_BYTES != 2 && BUS_BYTES != 4) begin : g_bad_bus_bytes
      $error("mem_arbiter: BUS_BYTES must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_win, r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [3:0]        r_sel;
  logic [31:0]       r_wdata;
  logic [BW-1:0]     r_beat;
  logic [31:0]       r_rbuf;

  logic [PW-1:0]     w_pick, w_idx;
  logic              w_found;
  logic [ADDR_W-1:0] w_paddr, w_pbase;
  logic              w_pwe;
  logic [3:0]        w_psel;
  logic [31:0]       w_pwdata;
  logic              w_last;
  logic [BW-1:0]     w_nbeat;
  logic [31:0]       w_rbuf_nxt;

  // Scan order starts just after the last grant in round-robin mode, at port 0
  // in fixed mode; the first requester in scan order wins.
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_PORTS; k++) begin
      if (PRIO_MODE != 0) w_idx = PW'((int'(r_last) + k) % N_PORTS);
      else                w_idx = PW'(k - 1);
      if (!w_found && i_req_valid[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_paddr  = i_req_addr[w_pick*ADDR_W +: ADDR_W];
  assign w_pbase  = w_paddr & ~ADDR_W'(3);
  assign w_pwe    = i_req_we[w_pick];
  assign w_psel   = i_req_sel[w_pick*4 +: 4];
  assign w_pwdata = i_req_wdata[w_pick*32 +: 32];

  assign w_last  = (r_beat == BW'(NBEATS - 1));
  assign w_nbeat = r_beat + 1'b1;

  // Read buffer including the beat completing this cycle, so the final beat
  // lands in o_rdata on the same edge that raises req_done.
  always_comb begin
    w_rbuf_nxt = r_rbuf;
    w_rbuf_nxt[r_beat*LW +: LW] = i_ext_rdata;
  end

  assign o_stallreq = i_req_valid & ~o_req_done;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_BUSY;
      S_BUSY:  if (i_ext_ready && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_win       <= '0;
      r_last      <= PW'(N_PORTS - 1);
      r_we        <= 1'b0;
      r_base      <= '0;
      r_sel       <= '0;
      r_wdata     <= '0;
      r_beat      <= '0;
      r_rbuf      <= '0;
      o_req_done  <= '0;
      o_rdata     <= '0;
      o_ext_ce    <= 1'b0;
      o_ext_we    <= 1'b0;
      o_ext_addr  <= '0;
      o_ext_mask  <= '0;
      o_ext_wdata <= '0;
    end else begin
      o_req_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win       <= w_pick;
            r_last      <= w_pick;
            r_we        <= w_pwe;
            r_base      <= w_pbase;
            r_sel       <= w_psel;
            r_wdata     <= w_pwdata;
            r_beat      <= '0;
            o_ext_ce    <= 1'b1;
            o_ext_we    <= w_pwe;
            o_ext_addr  <= w_pbase;
            o_ext_mask  <= w_pwe ? w_psel[BUS_BYTES-1:0] : '0;
            o_ext_wdata <= w_pwdata[LW-1:0];
          end
        end
        S_BUSY: begin
          if (i_ext_ready) begin
            r_rbuf <= w_rbuf_nxt;
            if (w_last) begin
              o_ext_ce          <= 1'b0;
              o_req_done[r_win] <= 1'b1;
              if (!r_we) o_rdata <= w_rbuf_nxt;
            end else begin
              r_beat      <= w_nbeat;
              o_ext_addr  <= r_base + ADDR_W'(int'(w_nbeat) * BUS_BYTES);
              o_ext_mask  <= r_we ? r_sel[w_nbeat*BUS_BYTES +: BUS_BYTES] : '0;
              o_ext_wdata <= r_wdata[w_nbeat*LW +: LW];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (1/2/4-byte buses, fixed and round-robin)
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Memory image: byte at a = {n,n} ^ a[11:4], n = a[1:0]+1
  // (0x1000..0x1003 -> 11 22 33 44, 0x40..0x43 -> 15 26 37 40).
  function automatic logic [7:0] fbyte(input logic [31:0] a);
    logic [3:0] n;
    n = {2'b00, a[1:0]} + 4'd1;
    return {n, n} ^ a[11:4];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // instance 1: 1-byte bus, fixed priority
  logic [1:0]  b1_valid = '0, b1_we = '0, b1_done, b1_stall;
  logic [63:0] b1_addr = '0, b1_wdata = '0;
  logic [7:0]  b1_sel = '0;
  logic [31:0] b1_rdata, b1_eaddr;
  logic        b1_ce, b1_ewe, b1_ready = 1'b1;
  logic [0:0]  b1_emask;
  logic [7:0]  b1_ewdata, b1_erdata;
  assign b1_erdata = fbyte(b1_eaddr);

  // instance 2: 2-byte bus, round-robin
  logic [1:0]  b2_valid = '0, b2_we = '0, b2_done, b2_stall;
  logic [63:0] b2_addr = '0, b2_wdata = '0;
  logic [7:0]  b2_sel = '0;
  logic [31:0] b2_rdata, b2_eaddr;
  logic        b2_ce, b2_ewe, b2_ready = 1'b0;
  logic [1:0]  b2_emask;
  logic [15:0] b2_ewdata, b2_erdata;
  assign b2_erdata = {fbyte(b2_eaddr + 32'd1), fbyte(b2_eaddr)};

  // instance 4: 4-byte bus, fixed priority
  logic [1:0]  b4_valid = '0, b4_we = '0, b4_done, b4_stall;
  logic [63:0] b4_addr = '0, b4_wdata = '0;
  logic [7:0]  b4_sel = '0;
  logic [31:0] b4_rdata, b4_eaddr;
  logic        b4_ce, b4_ewe, b4_ready = 1'b1;
  logic [3:0]  b4_emask;
  logic [31:0] b4_ewdata, b4_erdata;
  assign b4_erdata = {fbyte(b4_eaddr + 32'd3), fbyte(b4_eaddr + 32'd2),
                      fbyte(b4_eaddr + 32'd1), fbyte(b4_eaddr)};

  mem_arbiter #(.N_PORTS(2), .ADDR_W(32), .BUS_BYTES(1), .PRIO_MODE(0)) u_b1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(b1_valid), .i_req_we(b1_we),
    .i_req_addr(b1_addr), .i_req_sel(b1_sel), .i_req_wdata(b1_wdata),
    .o_req_done(b1_done), .o_rdata(b1_rdata), .o_stallreq(b1_stall),
    .o_ext_ce(b1_ce), .o_ext_we(b1_ewe), .o_ext_addr(b1_eaddr), .o_ext_mask(b1_emask),
    .o_ext_wdata(b1_ewdata), .i_ext_rdata(b1_erdata), .i_ext_ready(b1_ready));

  mem_arbiter #(.N_PORTS(2), .ADDR_W(32), .BUS_BYTES(2), .PRIO_MODE(1)) u_b2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(b2_valid), .i_req_we(b2_we),
    .i_req_addr(b2_addr), .i_req_sel(b2_sel), .i_req_wdata(b2_wdata),
    .o_req_done(b2_done), .o_rdata(b2_rdata), .o_stallreq(b2_stall),
    .o_ext_ce(b2_ce), .o_ext_we(b2_ewe), .o_ext_addr(b2_eaddr), .o_ext_mask(b2_emask),
    .o_ext_wdata(b2_ewdata), .i_ext_rdata(b2_erdata), .i_ext_ready(b2_ready));

  mem_arbiter #(.N_PORTS(2), .ADDR_W(32), .BUS_BYTES(4), .PRIO_MODE(0)) u_b4 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(b4_valid), .i_req_we(b4_we),
    .i_req_addr(b4_addr), .i_req_sel(b4_sel), .i_req_wdata(b4_wdata),
    .o_req_done(b4_done), .o_rdata(b4_rdata), .o_stallreq(b4_stall),
    .o_ext_ce(b4_ce), .o_ext_we(b4_ewe), .o_ext_addr(b4_eaddr), .o_ext_mask(b4_emask),
    .o_ext_wdata(b4_ewdata), .i_ext_rdata(b4_erdata), .i_ext_ready(b4_ready));

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] base;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  // One access on u_b1 with zero-wait memory; checks beat sequence and completion.
  task automatic run_b1(input vec_t v);
    int         cyc, nb;
    bit         seen, addr_ok;
    logic       st1, st_done;
    logic [3:0] omask;
    logic [31:0] owd;
    @(negedge clk);
    b1_valid[v.port] = 1'b1;
    b1_we[v.port]    = v.we;
    b1_addr[v.port*32 +: 32]  = v.addr;
    b1_sel[v.port*4 +: 4]     = v.sel;
    b1_wdata[v.port*32 +: 32] = v.wdata;
    cyc = 0; nb = 0; seen = 1'b0; addr_ok = 1'b1;
    omask = '0; owd = '0; st1 = 1'b0; st_done = 1'b1;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) st1 = b1_stall[v.port];
      if (b1_ce) begin
        if (nb < 4) begin
          omask[nb] = b1_emask[0];
          owd[nb*8 +: 8] = b1_ewdata;
          if (b1_eaddr !== v.base + 32'(nb)) addr_ok = 1'b0;
          if (b1_ewe !== v.we) addr_ok = 1'b0;
        end
        nb++;
      end
      if (b1_done != 2'b00) begin
        seen = 1'b1;
        st_done = b1_stall[v.port];
      end
    end
    chk("tbl_latency", 64'(cyc), 64'd5);
    chk("tbl_done_port", 64'(b1_done), 64'(2'b01 << v.port));
    chk("tbl_nbeats", 64'(nb), 64'd4);
    chk("tbl_beat_addr_we", 64'(addr_ok), 64'd1);
    chk("tbl_rdata", 64'(b1_rdata), 64'(v.exp_rdata));
    chk("tbl_mask", 64'(omask), 64'(v.we ? v.sel : 4'h0));
    chk("tbl_stall_busy", 64'(st1), 64'd1);
    chk("tbl_stall_done", 64'(st_done), 64'd0);
    if (v.we) chk("tbl_wdata", 64'(owd), 64'(v.wdata));
    b1_valid[v.port] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit seen;
    //         port we    addr          sel    wdata          base          rdata
    vecs[0] = '{0, 1'b0, 32'h0000_1003, 4'h0, 32'h0,         32'h0000_1000, 32'h4433_2211};
    vecs[1] = '{1, 1'b0, 32'h0000_0040, 4'h0, 32'h0,         32'h0000_0040, 32'h4037_2615};
    vecs[2] = '{0, 1'b1, 32'h0000_0100, 4'h5, 32'hDEAD_BEEF, 32'h0000_0100, 32'h4037_2615};
    vecs[3] = '{1, 1'b0, 32'h0000_0234, 4'h0, 32'h0,         32'h0000_0234, 32'h6710_0132};
    vecs[4] = '{1, 1'b1, 32'h0000_0FFE, 4'hF, 32'h1234_5678, 32'h0000_0FFC, 32'h6710_0132};
    vecs[5] = '{0, 1'b0, 32'h0000_0FFF, 4'h0, 32'h0,         32'h0000_0FFC, 32'hBBCC_DDEE};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_b1_ce", 64'(b1_ce), 64'd0);
    chk("rst_b1_done", 64'(b1_done), 64'd0);
    chk("rst_b1_rdata", 64'(b1_rdata), 64'd0);
    chk("rst_b1_ext", 64'({b1_ewe, b1_eaddr, b1_emask, b1_ewdata}), 64'd0);
    chk("rst_b2_out", 64'({b2_ce, b2_done, b2_ewe, b2_emask, b2_ewdata, b2_eaddr}), 64'd0);
    chk("rst_b2_rdata", 64'(b2_rdata), 64'd0);
    chk("rst_b4_out", 64'({b4_ce, b4_done, b4_ewe, b4_emask, b4_eaddr}), 64'd0);
    chk("rst_b4_data", 64'({b4_ewdata, b4_rdata}), 64'd0);
    rst = 1'b1;

    // 2-byte write, ready every 3rd cycle
    @(negedge clk);
    b2_valid = 2'b01; b2_we = 2'b01; b2_addr[31:0] = 32'h2000;
    b2_sel[3:0] = 4'b1100; b2_wdata[31:0] = 32'hAABB_CCDD; b2_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      b2_ready = (c == 3 || c == 6);
      if (c == 1) chk("wr_stall0", 64'(b2_stall[0]), 64'd1);
      if (c <= 3) begin
        chk("wr_b0_ce_we", 64'({b2_ce, b2_ewe}), 64'b11);
        chk("wr_b0_addr", 64'(b2_eaddr), 64'h2000);
        chk("wr_b0_mask", 64'(b2_emask), 64'b00);
        chk("wr_b0_data", 64'(b2_ewdata), 64'hCCDD);
      end else if (c <= 6) begin
        chk("wr_b1_ce", 64'(b2_ce), 64'd1);
        chk("wr_b1_addr", 64'(b2_eaddr), 64'h2002);
        chk("wr_b1_mask", 64'(b2_emask), 64'b11);
        chk("wr_b1_data", 64'(b2_ewdata), 64'hAABB);
      end else if (c == 7) begin
        chk("wr_done", 64'(b2_done), 64'b01);
        chk("wr_done_ce", 64'(b2_ce), 64'd0);
        b2_valid = 2'b00;
      end else begin
        chk("wr_done_single", 64'(b2_done), 64'b00);
      end
    end

    // round-robin: port 0 granted last, so port 1 goes first
    @(negedge clk);
    b2_ready = 1'b1; b2_we = 2'b00;
    b2_addr = {32'h0000_0040, 32'h0000_1000};
    b2_valid = 2'b11;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 5) chk("rr_stall_both", 64'(b2_stall), 64'b11);
      if (c == 3 || c == 11) begin
        chk("rr_done_p1", 64'(b2_done), 64'b10);
        chk("rr_rdata_p1", 64'(b2_rdata), 64'h4037_2615);
      end
      if (c == 7 || c == 15) begin
        chk("rr_done_p0", 64'(b2_done), 64'b01);
        chk("rr_rdata_p0", 64'(b2_rdata), 64'h4433_2211);
      end
      if (c == 4 || c == 9) chk("rr_idle_gap", 64'(b2_done), 64'b00);
    end
    b2_valid = 2'b00;

    // 4-byte bus: single beat
    @(negedge clk);
    b4_valid = 2'b01; b4_we = 2'b00; b4_addr[31:0] = 32'h40;
    @(negedge clk);
    chk("b4_beat_ce", 64'(b4_ce), 64'd1);
    chk("b4_beat_addr", 64'(b4_eaddr), 64'h40);
    chk("b4_beat_mask", 64'(b4_emask), 64'h0);
    @(negedge clk);
    chk("b4_done", 64'(b4_done), 64'b01);
    chk("b4_rdata", 64'(b4_rdata), 64'h4037_2615);
    chk("b4_done_ce", 64'(b4_ce), 64'd0);
    b4_valid = 2'b00;

    // table-driven accesses on the 1-byte bus
    for (int i = 0; i < 6; i++) run_b1(vecs[i]);

    // fixed priority: port 0 starves port 1 while it keeps requesting
    @(negedge clk);
    b1_we = 2'b00;
    b1_addr = {32'h0000_0040, 32'h0000_1000};
    b1_valid = 2'b11;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) chk("fp_stall_both", 64'(b1_stall), 64'b11);
      if (c == 5) begin
        chk("fp_done_first", 64'(b1_done), 64'b01);
        chk("fp_rdata_first", 64'(b1_rdata), 64'h4433_2211);
        chk("fp_stall_at_done", 64'(b1_stall), 64'b10);
      end
      if (c == 11) begin
        chk("fp_done_again_p0", 64'(b1_done), 64'b01);
        b1_valid[0] = 1'b0;
      end
      if (c == 17) begin
        chk("fp_done_p1", 64'(b1_done), 64'b10);
        chk("fp_rdata_p1", 64'(b1_rdata), 64'h4037_2615);
      end
    end
    b1_valid = 2'b00;

    // reset during beat 2 of a read
    @(negedge clk);
    b1_valid = 2'b01; b1_addr[31:0] = 32'h1000;
    repeat (3) @(negedge clk);
    chk("mid_pre_addr", 64'(b1_eaddr), 64'h1002);
    rst = 1'b0;
    #1;
    chk("mid_rst_ce", 64'(b1_ce), 64'd0);
    chk("mid_rst_done_addr", 64'({b1_done, b1_eaddr}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (b1_done != 2'b00) seen = 1'b1;
    end
    chk("post_rst_latency", 64'(cyc), 64'd5);
    chk("post_rst_done", 64'(b1_done), 64'b01);
    chk("post_rst_rdata", 64'(b1_rdata), 64'h4433_2211);
    b1_valid = 2'b00;

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
